// File: rtl/hood_display_scan_if.sv
// rtl/hood_display_scan_if.sv - range-hood display inputs and 8-digit scan outputs
interface hood_display_scan_if;
  logic       power_on;
  logic [1:0] page_sel;
  logic [5:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_second;
  logic [5:0] work_hours;
  logic [5:0] work_minutes;
  logic [5:0] hand_time;
  logic [3:0] state_smoke_lvl;
  logic       remind;
  logic [7:0] an;
  logic [7:0] seg;

  modport master (
    output power_on, page_sel, cur_hour, cur_min, cur_second,
    output work_hours, work_minutes, hand_time, state_smoke_lvl, remind,
    input  an, seg
  );

  modport slave (
    input  power_on, page_sel, cur_hour, cur_min, cur_second,
    input  work_hours, work_minutes, hand_time, state_smoke_lvl, remind,
    output an, seg
  );
endinterface

// File: rtl/hood_display_scan.sv
// rtl/hood_display_scan.sv - 8-digit 7-segment scanner with pages, frame shadowing and remind blink
// Optional macro DISP_LEAD_ZERO_BLANK_EN blanks a zero tens digit for hours, work hours and hand timer.
module hood_display_scan #(
  parameter int CLK_HZ       = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic                clk,
  input  logic                reset,
  hood_display_scan_if.slave  disp
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [4:0] SYM_DASH  = 5'd16;
  localparam logic [4:0] SYM_L     = 5'd17;
  localparam logic [4:0] SYM_BLANK = 5'd18;

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic       sh_power_q, sh_power_d;
  logic [1:0] sh_page_q, sh_page_d;
  logic [5:0] sh_hour_q, sh_hour_d;
  logic [5:0] sh_min_q, sh_min_d;
  logic [5:0] sh_sec_q, sh_sec_d;
  logic [5:0] sh_wh_q, sh_wh_d;
  logic [5:0] sh_wm_q, sh_wm_d;
  logic [5:0] sh_hand_q, sh_hand_d;
  logic [3:0] sh_lvl_q, sh_lvl_d;
  logic       sh_remind_q, sh_remind_d;

  logic       tick;
  logic       frame_wrap;
  logic [4:0] sym;
  logic [7:0] hour_bcd, min_bcd, sec_bcd, wh_bcd, wm_bcd, hand_bcd;

  // Repeated subtract of ten; six passes cover the full 0..63 range.
  function automatic logic [7:0] bcd_split(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int k = 0; k < 6; k++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [4:0] tens_sym(input logic [3:0] t);
`ifdef DISP_LEAD_ZERO_BLANK_EN
    return (t == 4'd0) ? SYM_BLANK : {1'b0, t};
`else
    return {1'b0, t};
`endif
  endfunction

  function automatic logic [6:0] seg_code(input logic [4:0] s);
    case (s)
      5'd0:    return 7'h3F;
      5'd1:    return 7'h06;
      5'd2:    return 7'h5B;
      5'd3:    return 7'h4F;
      5'd4:    return 7'h66;
      5'd5:    return 7'h6D;
      5'd6:    return 7'h7D;
      5'd7:    return 7'h07;
      5'd8:    return 7'h7F;
      5'd9:    return 7'h6F;
      5'd10:   return 7'h77;
      5'd11:   return 7'h7C;
      5'd12:   return 7'h39;
      5'd13:   return 7'h5E;
      5'd14:   return 7'h79;
      5'd15:   return 7'h71;
      SYM_DASH: return 7'h40;
      SYM_L:   return 7'h38;
      default: return 7'h00;
    endcase
  endfunction

  // Counters, shadow capture at the frame boundary and blink phase.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    sh_power_d  = sh_power_q;
    sh_page_d   = sh_page_q;
    sh_hour_d   = sh_hour_q;
    sh_min_d    = sh_min_q;
    sh_sec_d    = sh_sec_q;
    sh_wh_d     = sh_wh_q;
    sh_wm_d     = sh_wm_q;
    sh_hand_d   = sh_hand_q;
    sh_lvl_d    = sh_lvl_q;
    sh_remind_d = sh_remind_q;

    tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    frame_wrap = tick && (idx_q == 3'd7);

    if (tick) begin
      tick_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end

    if (frame_wrap) begin
      sh_power_d  = disp.power_on;
      sh_page_d   = disp.page_sel;
      sh_hour_d   = disp.cur_hour;
      sh_min_d    = disp.cur_min;
      sh_sec_d    = disp.cur_second;
      sh_wh_d     = disp.work_hours;
      sh_wm_d     = disp.work_minutes;
      sh_hand_d   = disp.hand_time;
      sh_lvl_d    = disp.state_smoke_lvl;
      sh_remind_d = disp.remind;
      // Only frames completed under remind count; a fresh remind starts ON at frame 0.
      if (disp.remind && sh_remind_q) begin
        if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FRM_W'(1);
        end
      end else begin
        frame_cnt_d = '0;
        blink_on_d  = 1'b1;
      end
    end
  end

  assign hour_bcd = bcd_split(sh_hour_d);
  assign min_bcd  = bcd_split(sh_min_d);
  assign sec_bcd  = bcd_split(sh_sec_d);
  assign wh_bcd   = bcd_split(sh_wh_d);
  assign wm_bcd   = bcd_split(sh_wm_d);
  assign hand_bcd = bcd_split(sh_hand_d);

  // Output is built from next-state values so it lands one clock after the tick.
  always_comb begin
    sym   = SYM_BLANK;
    an_d  = an_q;
    seg_d = seg_q;

    case (sh_page_d)
      2'd0: begin
        case (idx_d)
          3'd7:    sym = tens_sym(hour_bcd[7:4]);
          3'd6:    sym = {1'b0, hour_bcd[3:0]};
          3'd4:    sym = {1'b0, min_bcd[7:4]};
          3'd3:    sym = {1'b0, min_bcd[3:0]};
          3'd1:    sym = {1'b0, sec_bcd[7:4]};
          3'd0:    sym = {1'b0, sec_bcd[3:0]};
          default: sym = SYM_DASH;
        endcase
      end
      2'd1: begin
        case (idx_d)
          3'd7:    sym = tens_sym(wh_bcd[7:4]);
          3'd6:    sym = {1'b0, wh_bcd[3:0]};
          3'd5:    sym = SYM_DASH;
          3'd4:    sym = {1'b0, wm_bcd[7:4]};
          3'd3:    sym = {1'b0, wm_bcd[3:0]};
          default: sym = SYM_BLANK;
        endcase
      end
      2'd2: begin
        case (idx_d)
          3'd7:    sym = SYM_L;
          3'd6:    sym = {1'b0, sh_lvl_d};
          3'd1:    sym = tens_sym(hand_bcd[7:4]);
          3'd0:    sym = {1'b0, hand_bcd[3:0]};
          default: sym = SYM_BLANK;
        endcase
      end
      default: sym = SYM_BLANK;
    endcase

    if (tick) begin
      an_d  = 8'd1 << idx_d;
      seg_d = {1'b0, seg_code(sym)};
      if (!sh_power_d) begin
        an_d  = 8'h00;
        seg_d = 8'h00;
      end else if (sh_remind_d && !blink_on_d) begin
        an_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q  <= '0;
      idx_q       <= 3'd0;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= 8'h00;
      seg_q       <= 8'h00;
      sh_power_q  <= 1'b0;
      sh_page_q   <= 2'd0;
      sh_hour_q   <= 6'd0;
      sh_min_q    <= 6'd0;
      sh_sec_q    <= 6'd0;
      sh_wh_q     <= 6'd0;
      sh_wm_q     <= 6'd0;
      sh_hand_q   <= 6'd0;
      sh_lvl_q    <= 4'd0;
      sh_remind_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      sh_power_q  <= sh_power_d;
      sh_page_q   <= sh_page_d;
      sh_hour_q   <= sh_hour_d;
      sh_min_q    <= sh_min_d;
      sh_sec_q    <= sh_sec_d;
      sh_wh_q     <= sh_wh_d;
      sh_wm_q     <= sh_wm_d;
      sh_hand_q   <= sh_hand_d;
      sh_lvl_q    <= sh_lvl_d;
      sh_remind_q <= sh_remind_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;

endmodule
